// File: rtl/bram_dp_ctrl_pkg.sv
// Shared types and constants for the dual-port BRAM request/response controller.
// Holds the request bundle, default sizes and the credit counter width helper.
package bram_dp_ctrl_pkg;

  localparam int RAM_WIDTH_D     = 16;
  localparam int RAM_ADDR_BITS_D = 3;
  localparam int RSP_DEPTH_D     = 4;

  typedef struct packed {
    logic                       we;
    logic [RAM_ADDR_BITS_D-1:0] addr;
    logic [RAM_WIDTH_D-1:0]     data;
  } req_t;

  // Counter must hold 0..depth inclusive.
  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bram_dp_ctrl_rsp_fifo.sv
// Per-port read response FIFO; shows the head while valid, holds last data when empty.
// Ports: clk_i, rst_ni (sync, active-low), push_i/data_i in, pop_i in, valid_o/data_o out.
module bram_dp_ctrl_rsp_fifo
  import bram_dp_ctrl_pkg::*;
#(
  parameter int WIDTH = RAM_WIDTH_D,
  parameter int DEPTH = RSP_DEPTH_D
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PONE = AW'(1);
  localparam logic [AW:0]   CONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             do_pop;

  assign valid_o = (cnt_q != '0);
  assign do_pop  = pop_i && valid_o;
  assign data_o  = valid_o ? mem_q[rd_q] : last_q;

  always_comb begin
    wr_d   = push_i ? wr_q + PONE : wr_q;
    rd_d   = do_pop ? rd_q + PONE : rd_q;
    last_d = do_pop ? mem_q[rd_q] : last_q;
    cnt_d  = cnt_q;
    if (push_i && !do_pop) cnt_d = cnt_q + CONE;
    else if (!push_i && do_pop) cnt_d = cnt_q - CONE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/bram_dp_ctrl.sv
// Two-channel valid/ready front end for a true dual-port BRAM with credit-limited reads.
// Ports: clk_i, rst_ni, req_{a,b}_*, rsp_{a,b}_*, mem_*_{a,b}; option BRAM_DP_CTRL_COLLISION_EN.
module bram_dp_ctrl
  import bram_dp_ctrl_pkg::*;
#(
  parameter int RAM_WIDTH     = RAM_WIDTH_D,
  parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_D,
  parameter int RSP_DEPTH     = RSP_DEPTH_D
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_a_valid_i,
  output logic                     req_a_ready_o,
  input  logic                     req_a_we_i,
  input  logic [RAM_ADDR_BITS-1:0] req_a_addr_i,
  input  logic [RAM_WIDTH-1:0]     req_a_data_i,
  input  logic                     req_b_valid_i,
  output logic                     req_b_ready_o,
  input  logic                     req_b_we_i,
  input  logic [RAM_ADDR_BITS-1:0] req_b_addr_i,
  input  logic [RAM_WIDTH-1:0]     req_b_data_i,
  output logic                     rsp_a_valid_o,
  input  logic                     rsp_a_ready_i,
  output logic [RAM_WIDTH-1:0]     rsp_a_data_o,
  output logic                     rsp_b_valid_o,
  input  logic                     rsp_b_ready_i,
  output logic [RAM_WIDTH-1:0]     rsp_b_data_o,
  output logic                     mem_en_a_o,
  output logic                     mem_we_a_o,
  output logic [RAM_ADDR_BITS-1:0] mem_addr_a_o,
  output logic [RAM_WIDTH-1:0]     mem_data_a_o,
  input  logic [RAM_WIDTH-1:0]     mem_data_a_i,
  output logic                     mem_en_b_o,
  output logic                     mem_we_b_o,
  output logic [RAM_ADDR_BITS-1:0] mem_addr_b_o,
  output logic [RAM_WIDTH-1:0]     mem_data_b_o,
  input  logic [RAM_WIDTH-1:0]     mem_data_b_i
);

  localparam int CW = credit_w(RSP_DEPTH);
  localparam logic [CW-1:0] CRED_MAX = CW'(RSP_DEPTH);
  localparam logic [CW-1:0] CRED_ONE = CW'(1);

  logic [1:0] req_v, rdy, acc, stall;
  logic [1:0] rsp_v, rsp_rdy, hs, en;
  req_t       req [2];
  req_t       iss [2];
  logic [RAM_WIDTH-1:0] rdata [2];
  logic [RAM_WIDTH-1:0] rsp_data [2];

  assign req_v   = {req_b_valid_i, req_a_valid_i};
  assign rsp_rdy = {rsp_b_ready_i, rsp_a_ready_i};
  assign req[0]  = '{we: req_a_we_i, addr: req_a_addr_i, data: req_a_data_i};
  assign req[1]  = '{we: req_b_we_i, addr: req_b_addr_i, data: req_b_data_i};
  assign rdata[0] = mem_data_a_i;
  assign rdata[1] = mem_data_b_i;
  assign acc = req_v & rdy;
  assign hs  = rsp_v & rsp_rdy;

`ifdef BRAM_DP_CTRL_COLLISION_EN
  // B yields to A on any same-address pair involving a write.
  assign stall[0] = 1'b0;
  assign stall[1] = req_v[0] && req_v[1] &&
                    (req[0].addr == req[1].addr) &&
                    (req[0].we || req[1].we);
`else
  assign stall = 2'b00;
`endif

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [CW-1:0] cred_q, cred_d;
    req_t          iss_q, iss_d;
    logic          en_q, infl_q, rd_acc;

    assign rd_acc = acc[p] && !req[p].we;
    // Writes never consume credits, so only reads wait on them.
    assign rdy[p] = rst_ni && ((cred_q != '0) || req[p].we) && !stall[p];

    always_comb begin
      cred_d = cred_q;
      if (rd_acc && !hs[p]) cred_d = cred_q - CRED_ONE;
      else if (!rd_acc && hs[p]) cred_d = cred_q + CRED_ONE;
      // addr/data hold when idle; we drops so the port is quiet.
      iss_d    = iss_q;
      iss_d.we = 1'b0;
      if (acc[p]) iss_d = req[p];
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        cred_q <= CRED_MAX;
        iss_q  <= '0;
        en_q   <= 1'b0;
        infl_q <= 1'b0;
      end else begin
        cred_q <= cred_d;
        iss_q  <= iss_d;
        en_q   <= acc[p];
        infl_q <= en_q && !iss_q.we;
      end
    end

    bram_dp_ctrl_rsp_fifo #(
      .WIDTH (RAM_WIDTH),
      .DEPTH (RSP_DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (infl_q),
      .data_i  (rdata[p]),
      .pop_i   (rsp_rdy[p]),
      .valid_o (rsp_v[p]),
      .data_o  (rsp_data[p])
    );

    assign en[p]  = en_q;
    assign iss[p] = iss_q;
  end

  assign req_a_ready_o = rdy[0];
  assign req_b_ready_o = rdy[1];
  assign rsp_a_valid_o = rsp_v[0];
  assign rsp_b_valid_o = rsp_v[1];
  assign rsp_a_data_o  = rsp_data[0];
  assign rsp_b_data_o  = rsp_data[1];

  assign mem_en_a_o   = en[0];
  assign mem_we_a_o   = iss[0].we;
  assign mem_addr_a_o = iss[0].addr;
  assign mem_data_a_o = iss[0].data;
  assign mem_en_b_o   = en[1];
  assign mem_we_b_o   = iss[1].we;
  assign mem_addr_b_o = iss[1].addr;
  assign mem_data_b_o = iss[1].data;

endmodule
